// File: rtl/iir_pkg.sv
// Shared types, tap indices and the fixed-point saturation helper for the
// time-multiplexed biquad cascade.
package iir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SEC_END, OUT} state_t;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam int TAPS_PER_SEC = 5;

    localparam int FRAC_DEFAULT = 16;

    // Widest sample width the helper supports; narrower accumulators are
    // sign-extended into it by the caller.
    localparam int SAT_MAX_W = 64;
    localparam int SAT_ACC_W = 2 * SAT_MAX_W + 3;

    function automatic logic signed [SAT_MAX_W-1:0] sat(
        input logic signed [SAT_ACC_W-1:0] acc,
        input int bitwidth,
        input int frac
    );
        logic signed [SAT_ACC_W-1:0] sh;
        logic signed [SAT_ACC_W-1:0] hi;
        logic signed [SAT_ACC_W-1:0] lo;
        sh = acc >>> frac;
        hi = (SAT_ACC_W'(1) <<< (bitwidth - 1)) - SAT_ACC_W'(1);
        lo = ~hi;
        if (sh > hi) begin
            return SAT_MAX_W'(hi);
        end else if (sh < lo) begin
            return SAT_MAX_W'(lo);
        end else begin
            return SAT_MAX_W'(sh);
        end
    endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared multiply-accumulate unit: one signed product per cycle, added or
// subtracted into a guard-bit accumulator, with a saturated Q-format result.
module iir_mac_sat
    import iir_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int FRAC     = FRAC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       acc_clr,
    input  logic                       acc_en,
    input  logic                       sub,
    input  logic signed [BITWIDTH-1:0] coef,
    input  logic signed [BITWIDTH-1:0] data,
    output logic signed [BITWIDTH-1:0] res,
    output logic                       ovf_pulse
);

    localparam int PW    = 2 * BITWIDTH;
    localparam int ACC_W = PW + 3;

    logic signed [PW-1:0]    prod_p0;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] sh_p1;

    assign prod_p0 = PW'(coef) * PW'(data);

    // p0 -> p1: accumulate; three guard bits cover five full-scale products
    always_ff @(posedge clk) begin
        if (acc_clr) begin
            acc_p1 <= '0;
        end else if (acc_en) begin
            acc_p1 <= sub ? acc_p1 - ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);
        end
    end

    assign res       = BITWIDTH'(sat(SAT_ACC_W'(acc_p1), BITWIDTH, FRAC));
    assign sh_p1     = acc_p1 >>> FRAC;
    assign ovf_pulse = (sh_p1 != ACC_W'(res));

endmodule

// File: rtl/iir_sos_tdm.sv
// Direct Form I biquad cascade sharing one MAC across all sections and taps,
// with loadable coefficients, valid/ready handshakes and sticky saturation.
module iir_sos_tdm
    import iir_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int BITWIDTH = 32,
    parameter  int FRAC     = FRAC_DEFAULT,
    localparam int SECTIONS = (N + 1) / 2,
    localparam int AW       = $clog2(TAPS_PER_SEC * SECTIONS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITWIDTH-1:0] y,
    input  logic                       coef_we,
    input  logic [AW-1:0]              coef_addr,
    input  logic signed [BITWIDTH-1:0] coef_data,
    output logic                       coef_ready,
    output logic                       ovf
);

    localparam int NCOEF = TAPS_PER_SEC * SECTIONS;
    localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic [SW-1:0] LAST_SEC = SW'(SECTIONS - 1);
    localparam logic signed [BITWIDTH-1:0] ONE = BITWIDTH'(1) <<< FRAC;

    state_t                     state;
    logic [SW-1:0]              sec;
    logic [2:0]                 tap;
    logic signed [BITWIDTH-1:0] cur;
    logic signed [BITWIDTH-1:0] coef [NCOEF];
    logic signed [BITWIDTH-1:0] x1 [SECTIONS];
    logic signed [BITWIDTH-1:0] x2 [SECTIONS];
    logic signed [BITWIDTH-1:0] y1 [SECTIONS];
    logic signed [BITWIDTH-1:0] y2 [SECTIONS];

    logic [AW-1:0]              caddr;
    logic signed [BITWIDTH-1:0] opd;
    logic signed [BITWIDTH-1:0] res;
    logic                       ovf_pulse;
    logic                       acc_clr;
    logic                       acc_en;
    logic                       sub;

    assign caddr = AW'(int'(sec) * TAPS_PER_SEC + int'(tap));

    always_comb begin
        opd = cur;
        case (tap)
            TAP_B1:  opd = x1[sec];
            TAP_B2:  opd = x2[sec];
            TAP_A1:  opd = y1[sec];
            TAP_A2:  opd = y2[sec];
            default: opd = cur;
        endcase
    end

    assign acc_clr    = ((state == IDLE) && in_valid) || (state == SEC_END);
    assign acc_en     = (state == MAC);
    assign sub        = (tap >= TAP_A1);
    assign in_ready   = (state == IDLE);
    assign coef_ready = (state == IDLE);

    iir_mac_sat #(
        .BITWIDTH (BITWIDTH),
        .FRAC     (FRAC)
    ) u_mac (
        .clk       (clk),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .sub       (sub),
        .coef      (coef[caddr]),
        .data      (opd),
        .res       (res),
        .ovf_pulse (ovf_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sec       <= '0;
            tap       <= '0;
            cur       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            // Default coefficients make every section a unity passthrough
            for (int i = 0; i < NCOEF; i++) begin
                coef[i] <= ((i % TAPS_PER_SEC) == 0) ? ONE : '0;
            end
            for (int s = 0; s < SECTIONS; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else if (clr) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            for (int s = 0; s < SECTIONS; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < NCOEF)) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        cur   <= x;
                        sec   <= '0;
                        tap   <= TAP_B0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (tap == TAP_A2) begin
                        state <= SEC_END;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                SEC_END: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= cur;
                    y2[sec] <= y1[sec];
                    y1[sec] <= res;
                    cur     <= res;
                    if (ovf_pulse) begin
                        ovf <= 1'b1;
                    end
                    if (sec == LAST_SEC) begin
                        y         <= res;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        sec   <= sec + SW'(1);
                        tap   <= TAP_B0;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_sos_tdm.sv
// Bench for iir_sos_tdm (N=4, Q16.16): directed cases plus randomized samples
// and coefficient writes checked against a plain-arithmetic cascade model.
module tb_iir_sos_tdm;

    localparam int NSEC = 2;
    localparam int NC   = 5 * NSEC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        coef_we = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] coef_data = '0;
    logic [3:0]  coef_addr = '0;
    logic        in_ready;
    logic        out_valid;
    logic        coef_ready;
    logic        ovf;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    longint mc [NC];
    longint mx1 [NSEC];
    longint mx2 [NSEC];
    longint my1 [NSEC];
    longint my2 [NSEC];
    bit     m_ovf;

    always #5 clk = ~clk;

    iir_sos_tdm dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint q(input logic [31:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic logic signed [127:0] mul(input longint a, input longint b);
        logic signed [127:0] aa;
        logic signed [127:0] bb;
        aa = a;
        bb = b;
        return aa * bb;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NSEC; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        m_ovf = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mc[i] = ((i % 5) == 0) ? 64'sd65536 : 64'sd0;
        model_clear();
    endfunction

    // Cascade of biquads: y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, floor >>16, clamp
    function automatic logic [31:0] model_step(input longint xin);
        longint cur;
        longint r;
        logic signed [127:0] acc;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = 128'sd2147483647;
        lo = -hi - 128'sd1;
        cur = xin;
        for (int s = 0; s < NSEC; s++) begin
            acc = mul(mc[5*s], cur) + mul(mc[5*s+1], mx1[s]) + mul(mc[5*s+2], mx2[s])
                - mul(mc[5*s+3], my1[s]) - mul(mc[5*s+4], my2[s]);
            acc = acc >>> 16;
            if (acc > hi) begin
                r = 64'sd2147483647; m_ovf = 1'b1;
            end else if (acc < lo) begin
                r = -64'sd2147483648; m_ovf = 1'b1;
            end else begin
                r = longint'(acc);
            end
            mx2[s] = mx1[s]; mx1[s] = cur;
            my2[s] = my1[s]; my1[s] = r;
            cur = r;
        end
        return 32'(cur);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0; clr = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        chk("clr_ovf", 64'(ovf), 64'(0));
        chk("clr_out_valid", 64'(out_valid), 64'(0));
        chk("clr_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [31:0] d);
        chk("coef_ready_idle", 64'(coef_ready), 64'(1));
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_we = 1'b0;
        if (a < NC) mc[a] = q(d);
    endtask

    task automatic start(input logic [31:0] xv, input bit wr, input logic [3:0] wa,
                         input logic [31:0] wd, output logic [31:0] exp);
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1; x = xv;
        coef_we = wr; coef_addr = wa; coef_data = wd;
        tick();
        in_valid = 1'b0; coef_we = 1'b0;
        if (wr && wa < NC) mc[wa] = q(wd);
        exp = model_step(q(xv));
    endtask

    task automatic finish(input logic [31:0] exp, input int n0, input int hold,
                          output logic [31:0] got);
        int n;
        n = n0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(13));
        chk("y", 64'(y), 64'(exp));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        got = y;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; x = $urandom;
            tick();
            chk("bp_y", 64'(y), 64'(exp));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'(0));
        chk("in_ready_back", 64'(in_ready), 64'(1));
    endtask

    task automatic send(input logic [31:0] xv, input bit wr, input logic [3:0] wa,
                        input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic [31:0] exp;
        start(xv, wr, wa, wd, exp);
        finish(exp, 1, hold, got);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp;
        logic [31:0] rec_exp [4];
        int seen;
        rec_exp = '{32'h00008000, 32'h00004000, 32'h00002000, 32'h00001000};

        do_reset();
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_coef_ready", 64'(coef_ready), 64'(1));

        send(32'h00010000, 1'b0, 4'd0, 32'h0, 0, got);
        chk("pass_y", 64'(got), 64'(32'h00010000));

        // First-order recursion in section 0
        do_reset();
        wr_coef(4'd0, 32'h00008000);
        wr_coef(4'd3, 32'hFFFF8000);
        for (int k = 0; k < 4; k++) begin
            send((k == 0) ? 32'h00010000 : 32'h0, 1'b0, 4'd0, 32'h0, 0, got);
            chk("rec_y", 64'(got), 64'(rec_exp[k]));
        end

        // Saturation and sticky ovf
        do_reset();
        wr_coef(4'd0, 32'h7FFF0000);
        send(32'h00020000, 1'b0, 4'd0, 32'h0, 0, got);
        chk("sat_y", 64'(got), 64'(32'h7FFFFFFF));
        chk("sat_ovf", 64'(ovf), 64'(1));
        send(32'h0, 1'b0, 4'd0, 32'h0, 0, got);
        chk("sat_zero_y", 64'(got), 64'(0));
        chk("sat_sticky", 64'(ovf), 64'(1));
        do_clr();

        // Back-pressure
        do_reset();
        send(32'h00012345, 1'b0, 4'd0, 32'h0, 10, got);
        chk("bp_final_y", 64'(got), 64'(32'h00012345));

        // Coefficient write while busy is dropped
        do_reset();
        start(32'h00010000, 1'b0, 4'd0, 32'h0, exp);
        tick();
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h0;
        chk("busy_coef_ready", 64'(coef_ready), 64'(0));
        tick();
        coef_we = 1'b0;
        finish(exp, 3, 0, got);
        send(32'h00010000, 1'b0, 4'd0, 32'h0, 0, got);
        chk("busy_drop_y", 64'(got), 64'(32'h00010000));

        // Reset during section-1 MAC aborts the sample
        wr_coef(4'd5, 32'h00020000);
        start(32'h00050000, 1'b0, 4'd0, 32'h0, exp);
        repeat (8) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_abort", 64'(seen), 64'(0));
        send(32'h00030000, 1'b0, 4'd0, 32'h0, 0, got);
        chk("rst_mid_y", 64'(got), 64'(32'h00030000));

        // Randomized traffic, including same-edge writes and out-of-range addresses
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] xv;
            logic [31:0] cv;
            logic [3:0]  ca;
            bit          wr;
            if ($urandom_range(0, 3) == 0) begin
                cv = 32'($urandom_range(0, 131071)) - 32'd65536;
                wr_coef(4'($urandom_range(0, 15)), cv);
            end
            if ($urandom_range(0, 9) == 0) do_clr();
            xv = ($urandom_range(0, 1) == 0) ? $urandom
                                             : 32'($urandom_range(0, 524287)) - 32'd262144;
            wr = ($urandom_range(0, 3) == 0);
            ca = 4'($urandom_range(0, 15));
            cv = 32'($urandom_range(0, 131071)) - 32'd65536;
            send(xv, wr, ca, cv, $urandom_range(0, 3), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
